// File: rtl/pixel_ingress_scoreboard.sv
// Fragment ingress: skid FIFO, early-Z drop, per-pixel RMW hazard scoreboard, drain/flush, stats.
// Optional PIXEL_INGRESS_QUAD_MATCH_EN: hazard match at 2x2 quad granularity.
module pixel_ingress_scoreboard #(
    parameter int COORD_W    = 16,
    parameter int NUM_RT     = 4,
    parameter int PAYLOAD_W  = 192,
    parameter int FIFO_DEPTH = 4,
    parameter int SB_ENTRIES = 8,
    parameter int CNT_W      = 32,
    localparam int RT_W      = (NUM_RT > 1) ? $clog2(NUM_RT) : 1,
    localparam int TAG_W     = $clog2(SB_ENTRIES)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [COORD_W-1:0]   in_x,
    input  logic [COORD_W-1:0]   in_y,
    input  logic [RT_W-1:0]      in_rt,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic                 in_ez_valid,
    input  logic                 in_ez_kill,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [COORD_W-1:0]   out_x,
    output logic [COORD_W-1:0]   out_y,
    output logic [RT_W-1:0]      out_rt,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [TAG_W-1:0]     out_tag,
    input  logic                 ret_valid,
    input  logic [TAG_W-1:0]     ret_tag,
    input  logic                 flush_req,
    output logic                 flush_done,
    output logic                 busy,
    output logic                 err_ret_invalid,
    output logic [CNT_W-1:0]     stat_accept_cnt,
    output logic [CNT_W-1:0]     stat_kill_cnt,
    output logic [CNT_W-1:0]     stat_stall_cnt
);

    localparam int ENT_W = 2 * COORD_W + RT_W + PAYLOAD_W;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW    = PTR_W + 1;

`ifdef PIXEL_INGRESS_QUAD_MATCH_EN
    localparam int KEY_W = 2 * COORD_W + RT_W - 2;

    function automatic logic [KEY_W-1:0] mk_key(
        input logic [COORD_W-1:0] x,
        input logic [COORD_W-1:0] y,
        input logic [RT_W-1:0]    rt
    );
        return {x[COORD_W-1:1], y[COORD_W-1:1], rt};
    endfunction
`else
    localparam int KEY_W = 2 * COORD_W + RT_W;

    function automatic logic [KEY_W-1:0] mk_key(
        input logic [COORD_W-1:0] x,
        input logic [COORD_W-1:0] y,
        input logic [RT_W-1:0]    rt
    );
        return {x, y, rt};
    endfunction
`endif

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]       state;
    logic [ENT_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CW-1:0]    fifo_cnt;

    logic [SB_ENTRIES-1:0] sb_valid;
    logic [KEY_W-1:0]      sb_key [SB_ENTRIES];

    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 accept;
    logic                 kill;
    logic                 push;
    logic                 issue;
    logic                 stall;
    logic                 hazard;
    logic                 free_any;
    logic [TAG_W-1:0]     free_idx;
    logic                 drained;
    logic [ENT_W-1:0]     head;
    logic [COORD_W-1:0]   head_x;
    logic [COORD_W-1:0]   head_y;
    logic [RT_W-1:0]      head_rt;
    logic [PAYLOAD_W-1:0] head_payload;
    logic [KEY_W-1:0]     head_key;

    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == CW'(FIFO_DEPTH));
    assign in_ready   = (state == ST_RUN) && !fifo_full;
    assign accept     = in_valid && in_ready;
    assign kill       = in_ez_valid && in_ez_kill;
    assign push       = accept && !kill;

    assign head         = fifo_mem[rd_ptr];
    assign head_x       = head[ENT_W-1 -: COORD_W];
    assign head_y       = head[ENT_W-COORD_W-1 -: COORD_W];
    assign head_rt      = head[PAYLOAD_W +: RT_W];
    assign head_payload = head[PAYLOAD_W-1:0];
    assign head_key     = mk_key(head_x, head_y, head_rt);

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < SB_ENTRIES; i++) begin
            if (sb_valid[i] && (sb_key[i] == head_key)) hazard = 1'b1;
        end
    end

    // Scan downward so the lowest free index wins.
    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        for (int i = SB_ENTRIES - 1; i >= 0; i--) begin
            if (!sb_valid[i]) begin
                free_any = 1'b1;
                free_idx = TAG_W'(i);
            end
        end
    end

    assign issue   = !fifo_empty && !hazard && free_any && (!out_valid || out_ready);
    assign stall   = !fifo_empty && (hazard || !free_any);
    assign drained = fifo_empty && !out_valid && (sb_valid == '0);

    assign busy       = !fifo_empty || out_valid || (sb_valid != '0);
    assign flush_done = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {in_x, in_y, in_rt, in_payload};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (issue) rd_ptr <= rd_ptr + 1'b1;
            fifo_cnt <= fifo_cnt + CW'(push) - CW'(issue);
        end
    end

    // Retire is applied before allocate; they never name the same entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_valid        <= '0;
            err_ret_invalid <= 1'b0;
            for (int i = 0; i < SB_ENTRIES; i++) sb_key[i] <= '0;
        end else begin
            if (ret_valid) begin
                if (sb_valid[ret_tag]) sb_valid[ret_tag] <= 1'b0;
                else err_ret_invalid <= 1'b1;
            end
            if (issue) begin
                sb_valid[free_idx] <= 1'b1;
                sb_key[free_idx]   <= head_key;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_x       <= '0;
            out_y       <= '0;
            out_rt      <= '0;
            out_payload <= '0;
            out_tag     <= '0;
        end else if (issue) begin
            out_valid   <= 1'b1;
            out_x       <= head_x;
            out_y       <= head_y;
            out_rt      <= head_rt;
            out_payload <= head_payload;
            out_tag     <= free_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            case (state)
                ST_RUN:   if (flush_req) state <= ST_DRAIN;
                ST_DRAIN: if (drained) state <= ST_DONE;
                ST_DONE:  state <= ST_RUN;
                default:  state <= ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_accept_cnt <= '0;
            stat_kill_cnt   <= '0;
            stat_stall_cnt  <= '0;
        end else begin
            if (push && (stat_accept_cnt != '1))
                stat_accept_cnt <= stat_accept_cnt + 1'b1;
            if (accept && kill && (stat_kill_cnt != '1))
                stat_kill_cnt <= stat_kill_cnt + 1'b1;
            if (stall && (stat_stall_cnt != '1))
                stat_stall_cnt <= stat_stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pixel_ingress_scoreboard.sv
// Scoreboard bench for pixel_ingress_scoreboard: directed fragments, expected issues
// queued at send time and checked by an output monitor.
module tb_pixel_ingress_scoreboard;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [15:0]  in_x = '0;
    logic [15:0]  in_y = '0;
    logic [1:0]   in_rt = '0;
    logic [191:0] in_payload = '0;
    logic         in_ez_valid = 1'b0;
    logic         in_ez_kill = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [15:0]  out_x;
    logic [15:0]  out_y;
    logic [1:0]   out_rt;
    logic [191:0] out_payload;
    logic [2:0]   out_tag;
    logic         ret_valid = 1'b0;
    logic [2:0]   ret_tag = '0;
    logic         flush_req = 1'b0;
    logic         flush_done;
    logic         busy;
    logic         err_ret_invalid;
    logic [31:0]  stat_accept_cnt;
    logic [31:0]  stat_kill_cnt;
    logic [31:0]  stat_stall_cnt;

    pixel_ingress_scoreboard dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_rt(in_rt), .in_payload(in_payload),
        .in_ez_valid(in_ez_valid), .in_ez_kill(in_ez_kill),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_rt(out_rt),
        .out_payload(out_payload), .out_tag(out_tag),
        .ret_valid(ret_valid), .ret_tag(ret_tag),
        .flush_req(flush_req), .flush_done(flush_done), .busy(busy),
        .err_ret_invalid(err_ret_invalid),
        .stat_accept_cnt(stat_accept_cnt), .stat_kill_cnt(stat_kill_cnt),
        .stat_stall_cnt(stat_stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]  x;
        logic [15:0]  y;
        logic [1:0]   rt;
        logic [191:0] pl;
        logic [2:0]   tag;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int n_acc = 0;

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_issue: got x=%0d y=%0d rt=%0d tag=%0d, none expected",
                         out_x, out_y, out_rt, out_tag);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (out_x !== e.x || out_y !== e.y || out_rt !== e.rt ||
                    out_tag !== e.tag || out_payload !== e.pl) begin
                    errors++;
                    $display("FAIL issue: got x=%0d y=%0d rt=%0d tag=%0d pl=%h, want x=%0d y=%0d rt=%0d tag=%0d pl=%h",
                             out_x, out_y, out_rt, out_tag, out_payload,
                             e.x, e.y, e.rt, e.tag, e.pl);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [1:0] rt,
                        input logic ezv, input logic ezk, input logic [2:0] tag);
        exp_t e;
        logic [191:0] pl;
        int n;
        for (int k = 0; k < 6; k++) pl[k*32 +: 32] = $urandom();
        in_x = x;
        in_y = y;
        in_rt = rt;
        in_payload = pl;
        in_ez_valid = ezv;
        in_ez_kill = ezk;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready=0 want 1 (x=%0d)", x);
        end else if (!(ezv && ezk)) begin
            e.x = x; e.y = y; e.rt = rt; e.pl = pl; e.tag = tag;
            q.push_back(e);
            n_acc++;
        end
        tick();
        in_valid = 1'b0;
        in_ez_valid = 1'b0;
        in_ez_kill = 1'b0;
    endtask

    task automatic ret(input logic [2:0] t);
        ret_valid = 1'b1;
        ret_tag = t;
        tick();
        ret_valid = 1'b0;
    endtask

    task automatic wait_q(input int left);
        int n;
        n = 0;
        while (q.size() > left && n < 300) begin
            tick();
            n++;
        end
        if (q.size() > left) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending want %0d", q.size(), left);
        end
    endtask

    initial begin
        logic [31:0] s0;
        logic [15:0] hx;
        logic [2:0]  ht;
        int pulses;

        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_in_ready", 64'(in_ready), 1);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_flush_done", 64'(flush_done), 0);
        chk("rst_err", 64'(err_ret_invalid), 0);
        chk("rst_counters", 64'(stat_accept_cnt | stat_kill_cnt | stat_stall_cnt), 0);
        chk("rst_out_data", 64'(out_x | out_y | 16'(out_tag)), 0);

        // Single fragment latency
        send(5, 7, 0, 0, 0, 0);
        chk("t1_lat_n1", 64'(out_valid), 0);
        tick();
        chk("t1_lat_n2", 64'(out_valid), 1);
        wait_q(0);
        chk("t1_accept", 64'(stat_accept_cnt), 1);
        ret(0);
        tick();

        // Same pixel twice: RMW hazard
        send(5, 7, 0, 0, 0, 0);
        send(5, 7, 0, 0, 0, 0);
        tick();
        tick();
        s0 = stat_stall_cnt;
        repeat (4) tick();
        chk("t2_stall_delta", 64'(stat_stall_cnt - s0), 4);
        chk("t2_blocked", 64'(out_valid), 0);
        chk("t2_busy", 64'(busy), 1);
        ret(0);
        tick();
        chk("t2_reissue_valid", 64'(out_valid), 1);
        chk("t2_reissue_tag", 64'(out_tag), 0);
        wait_q(0);
        ret(0);
        tick();

`ifdef PIXEL_INGRESS_QUAD_MATCH_EN
        send(5, 7, 0, 0, 0, 0);
        send(4, 6, 0, 0, 0, 0);
        repeat (4) tick();
        chk("t3q_blocked", 64'(q.size()), 1);
        ret(0);
        wait_q(0);
        ret(0);
        tick();
`else
        s0 = stat_stall_cnt;
        send(5, 7, 0, 0, 0, 0);
        send(5, 7, 1, 0, 0, 1);
        send(6, 7, 0, 0, 0, 2);
        wait_q(0);
        chk("t3_no_stall", 64'(stat_stall_cnt - s0), 0);
        ret(0);
        ret(1);
        ret(2);
        tick();
`endif

        // Scoreboard full: ninth distinct pixel waits for a retire
        for (int i = 0; i < 9; i++)
            send(16'(10 + i), 20, 0, 0, 0, (i < 8) ? 3'(i) : 3'd3);
        wait_q(1);
        tick();
        s0 = stat_stall_cnt;
        repeat (3) tick();
        chk("t4_full_stall", 64'(stat_stall_cnt - s0), 3);
        chk("t4_ninth_blocked", 64'(out_valid), 0);
        ret(3);
        tick();
        chk("t4_ninth_valid", 64'(out_valid), 1);
        chk("t4_ninth_tag", 64'(out_tag), 3);
        wait_q(0);
        for (int t = 0; t < 8; t++) ret(3'(t));
        tick();
        chk("t4_err_clear", 64'(err_ret_invalid), 0);
        ret(3);
        tick();
        chk("t4_err_set", 64'(err_ret_invalid), 1);
        chk("t4_idle", 64'(busy), 0);

        // Early-Z kill
        send(30, 30, 0, 1, 1, 0);
        repeat (4) tick();
        chk("t5_kill_cnt", 64'(stat_kill_cnt), 1);
        chk("t5_kill_idle", 64'(busy), 0);
        send(31, 30, 0, 0, 1, 0);
        wait_q(0);
        chk("t5_accept_cnt", 64'(stat_accept_cnt), 64'(n_acc));
        ret(0);
        tick();

        // Back-pressure then flush
        out_ready = 1'b0;
        send(40, 0, 0, 0, 0, 0);
        send(41, 0, 0, 0, 0, 1);
        send(42, 0, 0, 0, 0, 2);
        hx = out_x;
        ht = out_tag;
        s0 = stat_stall_cnt;
        repeat (4) tick();
        chk("t6_hold_x", 64'(out_x), 64'(hx));
        chk("t6_hold_tag", 64'(ht), 0);
        chk("t6_hold_valid", 64'(out_valid), 1);
        chk("t6_bp_no_stall", 64'(stat_stall_cnt - s0), 0);
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        chk("t6_drain_in_ready", 64'(in_ready), 0);
        chk("t6_drain_x", 64'(out_x), 40);
        out_ready = 1'b1;
        wait_q(0);
        chk("t6_not_done", 64'(flush_done), 0);
        ret(0);
        ret(1);
        ret(2);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            if (flush_done) pulses++;
            tick();
        end
        chk("t6_done_pulses", 64'(pulses), 1);
        chk("t6_run_in_ready", 64'(in_ready), 1);

        // Reset in the middle of a drain
        out_ready = 1'b0;
        send(50, 0, 0, 0, 0, 0);
        send(51, 0, 0, 0, 0, 1);
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        tick();
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("r_out_valid", 64'(out_valid), 0);
        chk("r_busy", 64'(busy), 0);
        chk("r_in_ready", 64'(in_ready), 1);
        chk("r_err", 64'(err_ret_invalid), 0);
        chk("r_flush_done", 64'(flush_done), 0);
        chk("r_counters", 64'(stat_accept_cnt | stat_kill_cnt | stat_stall_cnt), 0);
        chk("r_out_data", 64'(out_x | out_y | 16'(out_tag)), 0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        send(60, 1, 2, 0, 0, 0);
        wait_q(0);
        chk("r_post_accept", 64'(stat_accept_cnt), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
